// File: rtl/mem_interface.sv
// mem_interface: MAR/MDR bus interface to a synchronous RAM with fixed read latency.
module mem_interface #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W = 9
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MDR_q,
  output logic [ADDR_W-1:0] MAR_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_re,
  output logic              ram_we,
  output logic              Ready,
  output logic              Busy,
  output logic              Err
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_PULSE} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [ADDR_W-1:0] acc_addr;
  logic idle, conflict, accept, start_rd, start_wr, rd_done, done, drop;
  always_comb begin
    idle     = state == IDLE;
    conflict = idle && Write && (MDRin || Read);
    accept   = idle && !conflict;
    start_rd = accept && MDRin && Read;
    start_wr = accept && Write;
    rd_done  = state == RD_WAIT && cnt == 4'd0;
    done     = rd_done || state == WR_PULSE;
    // A completing access signals Ready; requests on that edge are dropped silently so Ready and Err never coincide.
    drop     = !idle && !done && (MARin || MDRin || Write);
    state_n  = start_rd ? RD_WAIT : start_wr ? WR_PULSE : done ? IDLE : state;
    cnt_n    = start_rd ? 4'(WAIT_STATES - 1) : (state == RD_WAIT && cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      MAR_q    <= '0;
      MDR_q    <= '0;
      acc_addr <= '0;
      ram_re   <= 1'b0;
      ram_we   <= 1'b0;
      Ready    <= 1'b0;
      Err      <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      ram_re <= start_rd;
      ram_we <= start_wr;
      Ready  <= done;
      Err    <= conflict || drop;
      if (accept && MARin) MAR_q <= BusMuxOut[ADDR_W-1:0];
      if (accept && MDRin && !Read) MDR_q <= BusMuxOut;
      else if (rd_done) MDR_q <= ram_rdata;
      // The access keeps the pre-edge MAR even if MARin reloads it on the start edge.
      if (start_rd || start_wr) acc_addr <= MAR_q;
    end
  end
  assign Busy      = !idle;
  assign ram_addr  = idle ? MAR_q : acc_addr;
  assign ram_wdata = MDR_q;
endmodule

// File: doc/mem_interface.md
MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 Parameter WAIT_STATES, default 2, meaning RAM read latency in cycles from ram_re to valid ram_rdata; legal range 1..15.
REQ-002 Parameter ADDR_W, default 9, meaning RAM word-address width (512 x 32 memory).
REQ-003 Clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 BusMuxOut  input  32  datapath bus; source for MAR and MDR loads.
REQ-006 MARin  input  1  load MAR from BusMuxOut[ADDR_W-1:0].
REQ-007 MDRin  input  1  MDR load strobe; with Read=1 it starts a RAM read, with Read=0 it loads from the bus.
REQ-008 Read  input  1  read qualifier, sampled together with MDRin.
REQ-009 Write  input  1  start RAM write of MDR to address MAR.
REQ-010 ram_rdata  input  32  RAM read data.
REQ-011 MDR_q  output  32  MDR contents, driven to the bus mux.
REQ-012 MAR_q  output  ADDR_W  MAR contents.
REQ-013 ram_addr  output  ADDR_W  RAM address, equal to MAR_q.
REQ-014 ram_wdata  output  32  RAM write data, equal to MDR_q.
REQ-015 ram_re  output  1  registered RAM read strobe.
REQ-016 ram_we  output  1  registered RAM write strobe.
REQ-017 Ready  output  1  one-cycle completion pulse for a read or write.
REQ-018 Busy  output  1  high whenever the FSM is not in IDLE.
REQ-019 Err  output  1  one-cycle pulse on an illegal or dropped request.

Function
REQ-020 The FSM SHALL have states IDLE, RD_WAIT and WR_PULSE, with a 4-bit wait counter.
REQ-021 In IDLE, MARin=1 SHALL load MAR at the edge; in the same cycle, MDRin=1 with Read=0 SHALL load MDR from BusMuxOut.
REQ-022 In IDLE, MDRin=1 with Read=1 and Write=0 at edge N SHALL:
- set the state to RD_WAIT and the counter to WAIT_STATES-1;
- assert ram_re for exactly one cycle (N to N+1).
REQ-023 In RD_WAIT, the counter SHALL decrement each edge; at the edge where it reads 0 (edge N+WAIT_STATES), the block SHALL:
- load MDR from ram_rdata;
- assert Ready for one cycle;
- return to IDLE.
REQ-024 In IDLE, Write=1 with MDRin=0 at edge N SHALL:
- set the state to WR_PULSE;
- assert ram_we for one cycle, with ram_addr=MAR and ram_wdata=MDR.
REQ-025 From WR_PULSE, edge N+1 SHALL return the FSM to IDLE and assert Ready for one cycle; total write latency is 2 edges.
REQ-026 A MARin that coincides with a read/write start edge SHALL take effect at that edge, but the RAM access SHALL use the MAR value from before the edge.
REQ-027 The following conflicts in IDLE SHALL pulse Err for one cycle, leave MAR, MDR and FSM unchanged, and issue no RAM strobe:
- Write=1 with MDRin=1;
- Read=1 with Write=1.
REQ-028 While Busy=1, MARin, MDRin and Write SHALL be ignored (MAR/MDR locked); any of them asserted SHALL pulse Err.
REQ-029 Read=1 with MDRin=0 SHALL have no effect.
REQ-030 Ready and Err SHALL never be high in the same cycle.
REQ-031 ram_re and ram_we SHALL never be high in the same cycle.
REQ-032 A new request in the cycle Ready is high SHALL be accepted normally, since the FSM is already in IDLE.

Reset
REQ-033 Reset=1 at an edge SHALL force the following, overriding all other inputs:
- FSM to IDLE and counter to 0;
- MAR_q=0 and MDR_q=0;
- ram_re, ram_we, Ready, Busy and Err to 0.
REQ-034 Reset asserted mid-read or mid-write SHALL abort the access with no MDR update and no Ready pulse; the first request after deassertion SHALL be accepted.

Verification
REQ-035 Bus read: MARin with BusMuxOut=0x0000_0012, then MDRin+Read with ram_rdata=0xDEAD_BEEF from the RAM model after 2 cycles -> ram_re one cycle at addr 0x012, then Ready one cycle with MDR_q=0xDEAD_BEEF 2 edges after the start.
REQ-036 Write: MDRin (Read=0) with bus 0x1234_5678, MARin with bus 0x1FF, then Write -> ram_we one cycle with ram_addr=0x1FF and ram_wdata=0x1234_5678, then Ready one cycle later.
REQ-037 Conflicts: Read+Write+MDRin in IDLE -> Err one cycle, no ram_re/ram_we, MAR/MDR unchanged.
REQ-038 Busy lockout: MARin with bus 0x055 during RD_WAIT -> Err pulse, MAR_q unchanged, read completes with the original address.
REQ-039 Reset abort: Reset during RD_WAIT (WAIT_STATES=4) -> next cycle all outputs 0, no Ready; a following read completes normally.
REQ-040 Back-to-back: Write issued in the Ready cycle of a read -> accepted, ram_we next cycle, no Err.
